// File: rtl/rle_line_decoder_if.sv
// rtl/rle_line_decoder_if.sv - run-triple input and pixel-stream output bundle for rle_line_decoder
interface rle_line_decoder_if;
  logic [10:0] stream1;
  logic [10:0] stream2;
  logic [10:0] stream3;
  logic        in_valid;
  logic        in_ready;
  logic        pixel_out;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        len_err;

  modport master (
    output stream1, stream2, stream3, in_valid, out_ready,
    input  in_ready, pixel_out, out_valid, out_last, len_err
  );

  modport slave (
    input  stream1, stream2, stream3, in_valid, out_ready,
    output in_ready, pixel_out, out_valid, out_last, len_err
  );
endinterface

// File: rtl/rle_line_decoder.sv
// rtl/rle_line_decoder.sv - regenerates one IMAGE_W-pixel binary line from a black/white/black run triple
module rle_line_decoder #(
  parameter logic [10:0] IMAGE_W = 11'd20,
  parameter logic        BLACK   = 1'b0
) (
  input logic              CLK,
  input logic              reset_n,
  rle_line_decoder_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state, state_n;
  logic [10:0] s1, s1_n, s2, s2_n, x, x_n;
  logic        pix_r, pix_n, vld_r, vld_n, last_r, last_n, err_r, err_n;
  logic [12:0] sum;

  // 12-bit window compare so s1+s2 cannot wrap; clamping at line end falls out naturally
  function automatic logic pix_at(input logic [10:0] a, input logic [10:0] b, input logic [10:0] xi);
    logic [11:0] lo;
    logic [11:0] hi;
    logic [11:0] xx;
    lo = {1'b0, a};
    hi = {1'b0, a} + {1'b0, b};
    xx = {1'b0, xi};
    return (xx >= lo && xx < hi) ? ~BLACK : BLACK;
  endfunction

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      s1     <= '0;
      s2     <= '0;
      x      <= '0;
      pix_r  <= BLACK;
      vld_r  <= 1'b0;
      last_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_n;
      s1     <= s1_n;
      s2     <= s2_n;
      x      <= x_n;
      pix_r  <= pix_n;
      vld_r  <= vld_n;
      last_r <= last_n;
      err_r  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    s1_n    = s1;
    s2_n    = s2;
    x_n     = x;
    pix_n   = pix_r;
    vld_n   = vld_r;
    last_n  = last_r;
    err_n   = err_r;
    sum     = {2'b00, bus.stream1} + {2'b00, bus.stream2} + {2'b00, bus.stream3};
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          s1_n    = bus.stream1;
          s2_n    = bus.stream2;
          err_n   = (sum != {2'b00, IMAGE_W});
          x_n     = '0;
          vld_n   = 1'b1;
          pix_n   = pix_at(bus.stream1, bus.stream2, 11'd0);
          last_n  = (IMAGE_W == 11'd1);
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (x == IMAGE_W - 11'd1) begin
            x_n     = '0;
            vld_n   = 1'b0;
            last_n  = 1'b0;
            pix_n   = BLACK;
            state_n = IDLE;
          end else begin
            x_n    = x + 11'd1;
            pix_n  = pix_at(s1, s2, x + 11'd1);
            last_n = (x + 11'd1 == IMAGE_W - 11'd1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.pixel_out = pix_r;
  assign bus.out_valid = vld_r;
  assign bus.out_last  = last_r;
  assign bus.len_err   = err_r;

endmodule
